// File: rtl/binary_search_if.sv
// Handshake bundle between the search controller (master) and the requester/comparator side (slave).
interface binary_search_if #(
  parameter int unsigned N = 8
) ();
  logic         i_start;
  logic         i_abort;
  logic         i_greater;
  logic         i_equal;
  logic         i_less;
  logic [N-1:0] o_probe;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_result;
  logic         o_exact;

  modport master (
    input  i_start, i_abort, i_greater, i_equal, i_less,
    output o_probe, o_busy, o_done, o_result, o_exact
  );

  modport slave (
    output i_start, i_abort, i_greater, i_equal, i_less,
    input  o_probe, o_busy, o_done, o_result, o_exact
  );
endinterface

// File: rtl/binary_search.sv
// Successive-approximation search controller: finds an unknown value through a magnitude
// comparator by testing one bit per cycle, MSB first.
module binary_search #(
  parameter int unsigned N = 8
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  binary_search_if.master bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StSearch, StVerify, StDone} state_e;

  state_e         r_state;
  logic [IW-1:0]  r_idx;
  logic [N-1:0]   r_kept;
  logic [N-1:0]   r_probe;
  logic [N-1:0]   r_result;
  logic           r_exact;

  logic [IW-1:0]  w_idx_nxt;
  logic [N-1:0]   w_kept_nxt;
  logic [N-1:0]   w_probe_nxt;

  // Anything that is neither equal nor greater counts as less: the bit under test is dropped.
  always_comb begin
    w_idx_nxt   = r_idx - IW'(1);
    w_kept_nxt  = bus.i_greater ? r_probe : r_kept;
    w_probe_nxt = w_kept_nxt | (N'(1) << w_idx_nxt);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_kept   <= '0;
      r_probe  <= '0;
      r_result <= '0;
      r_exact  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_probe <= '0;
          if (bus.i_start) begin
            r_kept   <= '0;
            r_result <= '0;
            r_exact  <= 1'b0;
            r_idx    <= IW'(N - 1);
            r_probe  <= {1'b1, {(N-1){1'b0}}};
            r_state  <= StSearch;
          end
        end
        StSearch: begin
          if (bus.i_abort) begin
            r_probe <= '0;
            r_state <= StIdle;
          end else if (bus.i_equal) begin
            r_result <= r_probe;
            r_exact  <= 1'b1;
            r_probe  <= '0;
            r_state  <= StDone;
          end else begin
            r_kept <= w_kept_nxt;
            if (r_idx != '0) begin
              r_idx   <= w_idx_nxt;
              r_probe <= w_probe_nxt;
            end else begin
              r_probe <= '0;
              r_state <= StVerify;
            end
          end
        end
        StVerify: begin
          // Zero is the only target SEARCH can never hit exactly, so it is probed here.
          if (bus.i_abort) begin
            r_state <= StIdle;
          end else begin
            r_result <= r_kept;
            r_exact  <= bus.i_equal;
            r_state  <= StDone;
          end
        end
        StDone: begin
          r_probe <= '0;
          r_state <= StIdle;
        end
        default: begin
          r_probe <= '0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_probe  = r_probe;
  assign bus.o_busy   = (r_state == StSearch) || (r_state == StVerify);
  assign bus.o_done   = (r_state == StDone);
  assign bus.o_result = r_result;
  assign bus.o_exact  = r_exact;
endmodule
